// File: rtl/mult_pkg.sv
// Shared multiplier datapath definitions: product geometry and the
// residual row pair handed from the reduction tree to the final adder.
package mult_pkg;

   localparam int PROD_W = 32;
   localparam int HALF_W = PROD_W / 2;

   typedef struct packed {
      logic [PROD_W-1:0] sum;
      logic [PROD_W-1:0] carry;
   } row_pair_t;

   // Exact reference resolution of a row pair, including the carry out.
   function automatic logic [PROD_W:0] resolve_rows(input row_pair_t rp);
      return {1'b0, rp.sum} + {1'b0, rp.carry};
   endfunction

endpackage

// File: rtl/approx_half_adder_w.sv
// Combinational W-bit adder whose lowest APPROX_LSBS bits are a plain OR
// (no carry generation); the carry-in enters at the first exact bit.
module approx_half_adder_w #(
   parameter int W           = 16,
   parameter int APPROX_LSBS = 0
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   generate
      if (APPROX_LSBS == 0) begin : g_exact
         logic [W:0] full;
         assign full = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
         assign sum  = full[W-1:0];
         assign cout = full[W];
      end else if (APPROX_LSBS >= W) begin : g_or
         // Whole word approximated: the carry-in has nowhere to go but out.
         assign sum  = a | b;
         assign cout = cin;
      end else begin : g_mixed
         localparam int HW = W - APPROX_LSBS;
         logic [HW:0] upper;
         assign upper = {1'b0, a[W-1:APPROX_LSBS]} + {1'b0, b[W-1:APPROX_LSBS]}
                      + {{HW{1'b0}}, cin};
         assign sum   = {upper[HW-1:0], a[APPROX_LSBS-1:0] | b[APPROX_LSBS-1:0]};
         assign cout  = upper[HW];
      end
   endgenerate

endmodule

// File: rtl/mult_final_adder.sv
// Final carry-propagate stage of the multiplier: resolves the sum/carry rows
// into the product over two pipeline stages (low half, then high half).
module mult_final_adder
   import mult_pkg::*;
#(
   parameter int W           = PROD_W,
   parameter int APPROX_LSBS = 0,
   parameter int CNT_W       = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     row_a,
   input  logic [W-1:0]     row_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     product,
   output logic             carry_out,
   output logic [CNT_W-1:0] op_count
);

   localparam int H = W / 2;

   // Handshake: a transfer happens on any edge where valid && ready at that
   // interface. Each stage advances when it is empty or its successor
   // advances, so in_ready ripples combinationally back from out_ready.
   logic s1_adv, s2_adv;

   logic         s1_valid;
   logic [H-1:0] s1_lo;
   logic         s1_c1;
   logic [H-1:0] s1_hi_a;
   logic [H-1:0] s1_hi_b;

   logic         s2_valid;

   logic [H-1:0] lo_sum;
   logic         lo_cout;
   logic [H-1:0] hi_sum;
   logic         hi_cout;

   assign s2_adv    = !s2_valid || out_ready;
   assign s1_adv    = !s1_valid || s2_adv;
   assign in_ready  = s1_adv;
   assign out_valid = s2_valid;

   approx_half_adder_w #(
      .W           (H),
      .APPROX_LSBS (APPROX_LSBS)
   ) u_lo_add (
      .a    (row_a[H-1:0]),
      .b    (row_b[H-1:0]),
      .cin  (1'b0),
      .sum  (lo_sum),
      .cout (lo_cout)
   );

   approx_half_adder_w #(
      .W           (H),
      .APPROX_LSBS (0)
   ) u_hi_add (
      .a    (s1_hi_a),
      .b    (s1_hi_b),
      .cin  (s1_c1),
      .sum  (hi_sum),
      .cout (hi_cout)
   );

   // Stage 1: low-half sum, its carry, and the untouched high halves.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid <= 1'b0;
         s1_lo    <= '0;
         s1_c1    <= 1'b0;
         s1_hi_a  <= '0;
         s1_hi_b  <= '0;
      end else if (s1_adv) begin
         s1_valid <= in_valid;
         if (in_valid) begin
            s1_lo   <= lo_sum;
            s1_c1   <= lo_cout;
            s1_hi_a <= row_a[W-1:H];
            s1_hi_b <= row_b[W-1:H];
         end
      end
   end

   // Stage 2: data only loads from a valid S1 so outputs hold while idle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s2_valid  <= 1'b0;
         product   <= '0;
         carry_out <= 1'b0;
      end else if (s2_adv) begin
         s2_valid <= s1_valid;
         if (s1_valid) begin
            product   <= {hi_sum, s1_lo};
            carry_out <= hi_cout;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_count <= '0;
      end else if (out_valid && out_ready && (op_count != {CNT_W{1'b1}})) begin
         op_count <= op_count + CNT_W'(1);
      end
   end

endmodule
